// File: rtl/gpio_port_pkg.sv
// +------------------------------------------------------------------+
// | gpio_port_pkg : register map and pin mode encoding for GPIO port |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package gpio_port_pkg;

  localparam logic [2:0] c_ADDR_DIR        = 3'd0;
  localparam logic [2:0] c_ADDR_OUT        = 3'd1;
  localparam logic [2:0] c_ADDR_IN         = 3'd2;
  localparam logic [2:0] c_ADDR_IRQ_EN     = 3'd3;
  localparam logic [2:0] c_ADDR_IRQ_STATUS = 3'd4;
  localparam logic [2:0] c_ADDR_MODE0      = 3'd5;
  localparam logic [2:0] c_ADDR_MODE1      = 3'd6;

  // Encoded as {MODE1, MODE0}
  typedef enum logic [1:0] {
    RISE  = 2'b00,
    FALL  = 2'b01,
    BOTH  = 2'b10,
    LEVEL = 2'b11
  } gpio_mode_e;

endpackage

`default_nettype wire

// File: rtl/gpio_debounce.sv
// +------------------------------------------------------------------+
// | gpio_debounce : two-flop synchroniser plus hold-time filter      |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module gpio_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_stable,
  output logic o_update
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] c_CNT_MAX = CW'(DEBOUNCE - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_diff;

  assign w_diff   = r_sync2 ^ r_stable;
  // Pulses on the cycle the stable value is about to flip
  assign o_update = w_diff && (r_cnt == c_CNT_MAX);
  assign o_stable = r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      if (o_update) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpio_port_ctrl.sv
// +------------------------------------------------------------------+
// | gpio_port_ctrl : GPIO port with register file, debounce and IRQ  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module gpio_port_ctrl
  import gpio_port_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  input  logic             reg_wr,
  input  logic [2:0]       reg_addr,
  input  logic [WIDTH-1:0] reg_wdata,
  output logic [WIDTH-1:0] reg_rdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_irq_en;
  logic [WIDTH-1:0] r_mode0;
  logic [WIDTH-1:0] r_mode1;
  logic [WIDTH-1:0] r_status;
  logic             r_irq;

  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] w_evt;
  logic [WIDTH-1:0] w_w1c;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    gpio_mode_e w_mode;
    logic       w_stable;
    logic       w_upd;
    logic       w_rise;
    logic       w_fall;
    logic       w_level;

    gpio_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_din    (gpio_in[gi]),
      .o_stable (w_stable),
      .o_update (w_upd)
    );

    assign w_mode  = gpio_mode_e'({r_mode1[gi], r_mode0[gi]});
    assign w_rise  = w_upd & ~w_stable;
    assign w_fall  = w_upd &  w_stable;
    // Level mode looks at the value the stable flop holds after this edge
    assign w_level = w_stable ^ w_upd;

    assign w_evt[gi] = (w_mode == RISE) ? w_rise :
                       (w_mode == FALL) ? w_fall :
                       (w_mode == BOTH) ? w_upd  : w_level;
    assign w_in[gi]  = w_stable;
  end

  assign w_w1c = (reg_wr && (reg_addr == c_ADDR_IRQ_STATUS)) ? reg_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir    <= '0;
      r_out    <= '0;
      r_irq_en <= '0;
      r_mode0  <= '0;
      r_mode1  <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (reg_wr) begin
        case (reg_addr)
          c_ADDR_DIR:    r_dir    <= reg_wdata;
          c_ADDR_OUT:    r_out    <= reg_wdata;
          c_ADDR_IRQ_EN: r_irq_en <= reg_wdata;
          c_ADDR_MODE0:  r_mode0  <= reg_wdata;
          c_ADDR_MODE1:  r_mode1  <= reg_wdata;
          default: ;
        endcase
      end
      // A new event outranks a clear of the same bit
      r_status <= (r_status & ~w_w1c) | w_evt;
      r_irq    <= |(r_status & r_irq_en);
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      c_ADDR_DIR:        reg_rdata = r_dir;
      c_ADDR_OUT:        reg_rdata = r_out;
      c_ADDR_IN:         reg_rdata = w_in;
      c_ADDR_IRQ_EN:     reg_rdata = r_irq_en;
      c_ADDR_IRQ_STATUS: reg_rdata = r_status;
      c_ADDR_MODE0:      reg_rdata = r_mode0;
      c_ADDR_MODE1:      reg_rdata = r_mode1;
      default:           reg_rdata = '0;
    endcase
  end

  assign gpio_out = r_out;
  assign gpio_oe  = r_dir;
  assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_gpio_port_ctrl.sv
// +------------------------------------------------------------------+
// | tb_gpio_port_ctrl : directed self-checking bench for gpio_port   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_gpio_port_ctrl;

  localparam int WIDTH    = 8;
  localparam int DEBOUNCE = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] gpio_oe;
  logic             reg_wr;
  logic [2:0]       reg_addr;
  logic [WIDTH-1:0] reg_wdata;
  logic [WIDTH-1:0] reg_rdata;
  logic             irq;

  int n_total;
  int n_bad;

  gpio_port_ctrl #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [WIDTH-1:0] data);
    reg_wr    = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    step(1);
    reg_wr    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] addr, input logic [WIDTH-1:0] exp);
    reg_addr = addr;
    #1;
    check(tag, 32'(reg_rdata), 32'(exp));
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    gpio_in   = '0;
    reg_wr    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    step(2);
    check("rst_oe", 32'(gpio_oe), 32'h0);
    check("rst_out", 32'(gpio_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    step(1);
    rd("rst_status", 3'd4, 8'h00);

    // Register access
    wr(3'd0, 8'hF0);
    check("oe_after_wr", 32'(gpio_oe), 32'hF0);
    wr(3'd1, 8'hA5);
    check("out_after_wr", 32'(gpio_out), 32'hA5);
    rd("rd_dir", 3'd0, 8'hF0);
    rd("rd_out", 3'd1, 8'hA5);
    wr(3'd2, 8'hFF);
    rd("in_ro", 3'd2, 8'h00);
    wr(3'd7, 8'hFF);
    rd("addr7", 3'd7, 8'h00);

    // Glitch of 3 cycles at sync2 is rejected
    gpio_in[0] = 1'b1;
    step(3);
    gpio_in[0] = 1'b0;
    step(10);
    rd("glitch_in", 3'd2, 8'h00);
    rd("glitch_st", 3'd4, 8'h00);

    // Held input: IN updates exactly 5 edges after capture
    gpio_in[0] = 1'b1;
    step(5);
    rd("deb_in_early", 3'd2, 8'h00);
    step(1);
    rd("deb_in", 3'd2, 8'h01);
    rd("deb_status", 3'd4, 8'h01);

    // Masked status keeps irq low; enabling raises it one edge later
    step(2);
    check("mask_irq0", 32'(irq), 32'h0);
    wr(3'd3, 8'h01);
    check("mask_irq_wr", 32'(irq), 32'h0);
    step(1);
    check("mask_irq1", 32'(irq), 32'h1);

    // Falling edge in RISE mode is not an event; W1C drops irq next edge
    gpio_in[0] = 1'b0;
    step(8);
    rd("fall_in", 3'd2, 8'h00);
    wr(3'd4, 8'h01);
    rd("w1c_status", 3'd4, 8'h00);
    check("w1c_irq_hold", 32'(irq), 32'h1);
    step(1);
    check("w1c_irq_drop", 32'(irq), 32'h0);

    // Modes: pin0 RISE, pin1 FALL, pin2 BOTH, pin3 LEVEL
    wr(3'd5, 8'h0A);
    wr(3'd6, 8'h0C);
    wr(3'd3, 8'h0F);
    gpio_in[3:0] = 4'hF;
    step(5);
    rd("mode_pre", 3'd4, 8'h00);
    step(1);
    rd("mode_rise", 3'd4, 8'h0D);
    check("mode_irq_lat", 32'(irq), 32'h0);
    step(1);
    check("mode_irq", 32'(irq), 32'h1);
    gpio_in[3:0] = 4'h0;
    step(6);
    rd("mode_fall", 3'd4, 8'h0F);

    // Set wins over W1C on a level-high pin
    gpio_in[3] = 1'b1;
    step(7);
    wr(3'd4, 8'h08);
    rd("set_wins", 3'd4, 8'h0F);
    wr(3'd4, 8'h07);
    rd("w1c_low", 3'd4, 8'h08);
    gpio_in[3] = 1'b0;
    step(7);
    wr(3'd4, 8'h08);
    rd("w1c_level", 3'd4, 8'h00);
    check("lvl_irq_hold", 32'(irq), 32'h1);
    step(1);
    check("lvl_irq_drop", 32'(irq), 32'h0);

    // Asynchronous reset in the middle of a debounce count
    gpio_in[0] = 1'b1;
    step(3);
    rst_n = 1'b0;
    #2;
    check("arst_oe", 32'(gpio_oe), 32'h0);
    check("arst_out", 32'(gpio_out), 32'h0);
    rd("arst_mode1", 3'd6, 8'h00);
    step(2);
    rd("arst_in", 3'd2, 8'h00);
    rst_n = 1'b1;
    step(5);
    rd("arst_in_early", 3'd2, 8'h00);
    rd("arst_st_early", 3'd4, 8'h00);
    step(1);
    rd("arst_in_late", 3'd2, 8'h01);
    rd("arst_status", 3'd4, 8'h01);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
